// File: rtl/bsg_mcl_request_arbiter.sv
// bsg_mcl_request_arbiter
// Shares one outbound request FIFO port between num_req_p request streams.
// Grant is round-robin, combinational and gated by a credit counter that
// mirrors the endpoint's out-credits. A drain sequence lets software fence.
//
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   v_i, data_i, ready_o per-requester valid / packet / accept
//   v_o, data_o, ready_i granted packet toward the endpoint FIFO
//   grant_id_o           index of the granted requester (valid with v_o)
//   credit_return_i      one pulse per returned response
//   drain_i, drained_o   fence request level / fence complete
//   credits_o            available credits
//   error_o              sticky credit overflow
//
// Optional: define BSG_MCL_REQUEST_ARBITER_STARVE_CNT_EN to add per-requester
// wait counters with a running maximum on max_wait_o, cleared by
// max_wait_clear_i.

module bsg_mcl_request_arbiter #(
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned data_width_p      = 128,
    parameter int unsigned max_out_credits_p = 16,
    localparam int unsigned lg_num_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int unsigned credits_width_lp = $clog2(max_out_credits_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0]               v_i,
    input  logic [num_req_p*data_width_p-1:0]  data_i,
    output logic [num_req_p-1:0]               ready_o,
    output logic                               v_o,
    output logic [data_width_p-1:0]            data_o,
    input  logic                               ready_i,
    input  logic                               credit_return_i,
    input  logic                               drain_i,
    output logic                               drained_o,
    output logic [credits_width_lp-1:0]        credits_o,
    output logic [lg_num_req_lp-1:0]           grant_id_o,
`ifdef BSG_MCL_REQUEST_ARBITER_STARVE_CNT_EN
    output logic [15:0]                        max_wait_o,
    input  logic                               max_wait_clear_i,
`endif
    output logic                               error_o
);

    localparam logic [credits_width_lp-1:0] credits_max_lp = credits_width_lp'(max_out_credits_p);

    typedef enum logic [1:0] {
        STATE_RUN     = 2'd0,
        STATE_DRAIN   = 2'd1,
        STATE_DRAINED = 2'd2
    } state_e;

    state_e                      state_r, state_n;
    logic [lg_num_req_lp-1:0]    rr_ptr_r, rr_ptr_n;
    logic [credits_width_lp-1:0] credits_r, credits_n;
    logic                        error_r, error_n;
    logic [lg_num_req_lp-1:0]    sel;
    logic                        found;
    logic                        xfer;

    // Circular search from rr_ptr: first pass covers rr_ptr..N-1, second wraps to 0.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(num_req_p); i++) begin
            if (!found && v_i[i] && (lg_num_req_lp'(i) >= rr_ptr_r)) begin
                found = 1'b1;
                sel   = lg_num_req_lp'(i);
            end
        end
        for (int i = 0; i < int'(num_req_p); i++) begin
            if (!found && v_i[i]) begin
                found = 1'b1;
                sel   = lg_num_req_lp'(i);
            end
        end
    end

    // Output mux and per-requester accept; reset forces all handshakes low.
    always_comb begin
        v_o     = ~reset_i & (state_r == STATE_RUN) & (credits_r != '0) & found;
        xfer    = v_o & ready_i;
        data_o  = '0;
        ready_o = '0;
        for (int i = 0; i < int'(num_req_p); i++) begin
            if (sel == lg_num_req_lp'(i)) begin
                data_o     = data_i[i*data_width_p +: data_width_p];
                ready_o[i] = xfer;
            end
        end
    end

    assign grant_id_o = sel;
    assign credits_o  = credits_r;
    assign error_o    = error_r;
    assign drained_o  = (state_r == STATE_DRAINED);

    // Pointer and credit next-state; a return with the counter full is an overflow.
    always_comb begin
        rr_ptr_n  = rr_ptr_r;
        credits_n = credits_r;
        error_n   = error_r;
        if (xfer) begin
            rr_ptr_n = (sel == lg_num_req_lp'(num_req_p - 1)) ? '0 : sel + lg_num_req_lp'(1);
        end
        if (xfer && !credit_return_i) begin
            credits_n = credits_r - credits_width_lp'(1);
        end else if (!xfer && credit_return_i) begin
            if (credits_r == credits_max_lp) begin
                error_n = 1'b1;
            end else begin
                credits_n = credits_r + credits_width_lp'(1);
            end
        end
    end

    // Drain FSM next-state; dropping drain_i always returns to RUN.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            STATE_RUN: begin
                if (drain_i) state_n = STATE_DRAIN;
            end
            STATE_DRAIN: begin
                if (!drain_i)                        state_n = STATE_RUN;
                else if (credits_r == credits_max_lp) state_n = STATE_DRAINED;
            end
            STATE_DRAINED: begin
                if (!drain_i) state_n = STATE_RUN;
            end
            default: state_n = STATE_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= STATE_RUN;
            rr_ptr_r  <= '0;
            credits_r <= credits_max_lp;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            rr_ptr_r  <= rr_ptr_n;
            credits_r <= credits_n;
            error_r   <= error_n;
        end
    end

`ifdef BSG_MCL_REQUEST_ARBITER_STARVE_CNT_EN
    logic [15:0] wait_cnt_r [num_req_p];
    logic [15:0] max_wait_r;
    logic [15:0] wait_max_c;

    // Largest of the current wait counters and the running maximum.
    always_comb begin
        wait_max_c = max_wait_r;
        for (int i = 0; i < int'(num_req_p); i++) begin
            if (wait_cnt_r[i] > wait_max_c) wait_max_c = wait_cnt_r[i];
        end
    end

    // Saturating wait counters, cleared by the requester's own transfer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(num_req_p); i++) wait_cnt_r[i] <= '0;
            max_wait_r <= '0;
        end else begin
            for (int i = 0; i < int'(num_req_p); i++) begin
                if (v_i[i] && ready_o[i])                      wait_cnt_r[i] <= '0;
                else if (v_i[i] && wait_cnt_r[i] != 16'hFFFF)  wait_cnt_r[i] <= wait_cnt_r[i] + 16'd1;
            end
            max_wait_r <= max_wait_clear_i ? 16'd0 : wait_max_c;
        end
    end

    assign max_wait_o = max_wait_r;
`endif

endmodule

// File: tb/tb_bsg_mcl_request_arbiter.sv
// Self-checking bench for bsg_mcl_request_arbiter (2 requesters, 16 credits).
// A behavioural model tracks credits, round-robin pointer and drain phase
// with integer arithmetic; every cycle the DUT outputs are compared to it.

module tb_bsg_mcl_request_arbiter;

    localparam int N    = 2;
    localparam int W    = 128;
    localparam int MAXC = 16;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [N-1:0]     v_i;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     ready_o;
    logic             v_o;
    logic [W-1:0]     data_o;
    logic             ready_i;
    logic             credit_return_i;
    logic             drain_i;
    logic             drained_o;
    logic [4:0]       credits_o;
    logic [0:0]       grant_id_o;
    logic             error_o;
`ifdef BSG_MCL_REQUEST_ARBITER_STARVE_CNT_EN
    logic [15:0]      max_wait_o;
    logic             max_wait_clear_i = 1'b0;
`endif

    bsg_mcl_request_arbiter #(
        .num_req_p(N), .data_width_p(W), .max_out_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
        .credit_return_i(credit_return_i), .drain_i(drain_i),
        .drained_o(drained_o), .credits_o(credits_o), .grant_id_o(grant_id_o),
`ifdef BSG_MCL_REQUEST_ARBITER_STARVE_CNT_EN
        .max_wait_o(max_wait_o), .max_wait_clear_i(max_wait_clear_i),
`endif
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: phase 0=run, 1=draining, 2=drained.
    int m_cred, m_ptr, m_phase;
    bit m_err;

    // Observations from the most recent step.
    bit obs_v, obs_xfer;
    int obs_gid;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cred  = MAXC;
        m_ptr   = 0;
        m_phase = 0;
        m_err   = 0;
    endtask

    task automatic rand_data();
        for (int j = 0; j < N*W/32; j++) data_i[j*32 +: 32] = $urandom;
    endtask

    // One clock: check outputs at negedge against the model, then advance it.
    task automatic step();
        int sel;
        int idx;
        bit ev;
        bit xf;
        logic [N-1:0] er;
        @(negedge clk);
        sel = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (sel < 0 && v_i[idx]) sel = idx;
        end
        ev = (m_phase == 0) && (m_cred != 0) && (sel >= 0);
        xf = ev && ready_i;
        er = '0;
        if (xf) er[sel] = 1'b1;
        check("v_o", 128'(v_o), 128'(ev));
        check("ready_o", 128'(ready_o), 128'(er));
        check("credits_o", 128'(credits_o), 128'(m_cred));
        check("drained_o", 128'(drained_o), 128'(m_phase == 2));
        check("error_o", 128'(error_o), 128'(m_err));
        if (ev) begin
            check("grant_id_o", 128'(grant_id_o), 128'(sel));
            check("data_o", data_o, data_i[sel*W +: W]);
        end
        obs_v    = v_o;
        obs_xfer = v_o & ready_i;
        obs_gid  = int'(grant_id_o);
        @(posedge clk);
        case (m_phase)
            0: if (drain_i) m_phase = 1;
            1: if (!drain_i) m_phase = 0; else if (m_cred == MAXC) m_phase = 2;
            default: if (!drain_i) m_phase = 0;
        endcase
        if (xf && !credit_return_i) m_cred--;
        else if (!xf && credit_return_i) begin
            if (m_cred == MAXC) m_err = 1;
            else m_cred++;
        end
        if (xf) m_ptr = (sel + 1) % N;
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic rdy, input logic ret, input logic drn);
        v_i = v; ready_i = rdy; credit_return_i = ret; drain_i = drn;
        rand_data();
    endtask

    initial begin
        int n;
        reset_i = 1'b1;
        set_in(2'b11, 1'b1, 1'b0, 1'b0);
        model_reset();
        #7;
        check("rst_v_o", 128'(v_o), 128'(0));
        check("rst_ready_o", 128'(ready_o), 128'(0));
        check("rst_credits", 128'(credits_o), 128'(MAXC));
        check("rst_drained", 128'(drained_o), 128'(0));
        check("rst_error", 128'(error_o), 128'(0));
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Fairness: both requesting, returns every cycle.
        for (int k = 0; k < 6; k++) begin
            set_in(2'b11, 1'b1, 1'b1, 1'b0);
            step();
            check("rr_alternate", 128'(obs_gid), 128'(k % 2));
        end
        check("rr_credits", 128'(credits_o), 128'(MAXC));

        // Credit exhaustion.
        n = 0;
        for (int k = 0; k < 20; k++) begin
            set_in(2'b01, 1'b1, 1'b0, 1'b0);
            step();
            n += int'(obs_xfer);
        end
        check("exh_count", 128'(n), 128'(MAXC));
        check("exh_credits", 128'(credits_o), 128'(0));
        set_in(2'b01, 1'b1, 1'b1, 1'b0);
        step();
        check("exh_ret_same_cycle", 128'(obs_v), 128'(0));
        n = 0;
        for (int k = 0; k < 3; k++) begin
            set_in(2'b01, 1'b1, 1'b0, 1'b0);
            step();
            n += int'(obs_xfer);
        end
        check("exh_one_more", 128'(n), 128'(1));

        // Simultaneous transfer and return at credits=5.
        for (int k = 0; k < 5; k++) begin set_in(2'b00, 1'b1, 1'b1, 1'b0); step(); end
        check("sim_pre", 128'(credits_o), 128'(5));
        for (int k = 0; k < 3; k++) begin set_in(2'b01, 1'b1, 1'b1, 1'b0); step(); end
        check("sim_credits", 128'(credits_o), 128'(5));

        // Drain sequence.
        for (int k = 0; k < 11; k++) begin set_in(2'b00, 1'b1, 1'b1, 1'b0); step(); end
        for (int k = 0; k < 3; k++) begin set_in(2'b10, 1'b1, 1'b0, 1'b0); step(); end
        check("drn_issued", 128'(credits_o), 128'(13));
        set_in(2'b00, 1'b1, 1'b0, 1'b1); step();
        set_in(2'b11, 1'b1, 1'b0, 1'b1); step();
        check("drn_blocked", 128'(obs_v), 128'(0));
        for (int k = 0; k < 3; k++) begin set_in(2'b11, 1'b1, 1'b1, 1'b1); step(); end
        check("drn_full", 128'(credits_o), 128'(MAXC));
        check("drn_not_yet", 128'(drained_o), 128'(0));
        set_in(2'b11, 1'b1, 1'b0, 1'b1); step();
        check("drn_drained", 128'(drained_o), 128'(1));
        set_in(2'b11, 1'b1, 1'b0, 1'b0); step();
        set_in(2'b11, 1'b1, 1'b0, 1'b0); step();
        check("drn_resume", 128'(obs_v), 128'(1));

        // Overflow: return with counter full.
        set_in(2'b00, 1'b1, 1'b1, 1'b0); step();
        set_in(2'b00, 1'b1, 1'b1, 1'b0); step();
        set_in(2'b00, 1'b1, 1'b0, 1'b0); step();
        check("ovf_error", 128'(error_o), 128'(1));
        check("ovf_credits", 128'(credits_o), 128'(MAXC));

        // Random traffic with an async reset in the middle.
        drain_i = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                #2;
                reset_i = 1'b1;
                #1;
                check("arst_v_o", 128'(v_o), 128'(0));
                check("arst_credits", 128'(credits_o), 128'(MAXC));
                check("arst_error", 128'(error_o), 128'(0));
                model_reset();
                @(posedge clk); #1;
                reset_i = 1'b0;
            end
            set_in(2'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0,
                   (($urandom % 40) == 0) ? ~drain_i : drain_i);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_mcl_request_arbiter.md
Name: bsg_mcl_request_arbiter

Overview:
- Shares the manycore endpoint's single 128-bit outbound request FIFO port between N host-side 128-bit request streams. Each stream is a deserialized AXIL slot.
- Round-robin grant, gated by an outstanding-request credit counter that mirrors the endpoint's out-credits.
- Provides a drain sequence so host software can fence: stop issuing, wait for all credits to return, then report drained.
- Sits between the per-slot serial-in-parallel-out stages and the endpoint-to-FIFOs request input.

Parameters:
- num_req_p, 2, number of requesting streams (>=1).
- data_width_p, 128, packet width in bits.
- max_out_credits_p, 16, maximum outstanding requests; reset value of the credit counter.
- lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), localparam, grant id width.
- credits_width_lp, `BSG_WIDTH(max_out_credits_p), localparam.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  num_req_p  per-requester valid.
- data_i  in  num_req_p*data_width_p  per-requester packet.
- ready_o  out  num_req_p  per-requester accept; a transfer occurs on v_i[i]&ready_o[i].
- v_o  out  1  packet valid toward the endpoint.
- data_o  out  data_width_p  granted packet.
- ready_i  in  1  endpoint FIFO ready; a transfer occurs on v_o&ready_i.
- credit_return_i  in  1  one-cycle pulse per returned response.
- drain_i  in  1  level; request to fence.
- drained_o  out  1  high while in DRAINED state.
- credits_o  out  credits_width_lp  current available credits.
- grant_id_o  out  lg_num_req_lp  index of the current grant; valid when v_o=1.
- error_o  out  1  sticky credit overflow flag.

Behaviour:
- Reset values (async assert): rr_ptr=0, credits=max_out_credits_p, state=RUN, error_o=0. Outputs at reset: v_o=0, ready_o=0, drained_o=0.
- States and transitions:
  - RUN -> DRAIN when drain_i=1.
  - DRAIN -> DRAINED when credits==max_out_credits_p.
  - DRAINED -> RUN when drain_i=0.
  - DRAIN -> RUN when drain_i deasserts before drain completes.
- Grant logic is combinational, zero latency:
  - Selected requester = first i with v_i[i]=1, searching circularly starting at rr_ptr.
  - v_o = (state==RUN) & (credits!=0) & |v_i.
  - data_o and grant_id_o follow the selection.
  - ready_o[sel] = v_o & ready_i; all other ready_o bits are 0.
  - No requester sees ready_o without its own v_i.
- Round-robin pointer:
  - On a transfer, rr_ptr <= (sel==num_req_p-1) ? 0 : sel+1.
  - Otherwise rr_ptr holds.
  - The selection is not locked across cycles. A requester may withdraw v_i and the grant moves to the next valid requester in the same cycle.
- Credits:
  - Transfer only: decrement.
  - credit_return_i only: increment.
  - Both in the same cycle: unchanged.
  - credits==0 blocks issue; a return in the same cycle does not enable issue until the next cycle.
  - Return with credits==max and no transfer: counter holds at max, error_o sets and stays set until reset.
- drained_o is registered state, so it asserts one cycle after credits reach max in DRAIN.
- drain_i asserted in the same cycle as a transfer: that transfer completes, because the state is still RUN. No transfers occur from the next cycle on.
- num_req_p=1: rr_ptr stays 0 and grant_id_o is 0.
- Reset mid-operation: all state returns immediately to reset values. In-flight credits are forgotten; the endpoint must be reset in the same reset domain.

Optional Feature:
- Macro: BSG_MCL_REQUEST_ARBITER_STARVE_CNT_EN.
- Defined: adds output max_wait_o (16 bits) and input max_wait_clear_i (1 bit).
  - Per-requester counter increments each cycle v_i[i]=1 and ready_o[i]=0. It clears on that requester's transfer. It saturates at 16'hFFFF.
  - max_wait_o is a running maximum of all counters; max_wait_clear_i resets it to 0.
  - All counters reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Round-robin fairness: num_req_p=2, both v_i held, ready_i=1, returns every cycle -> grant_id_o alternates 0,1,0,1; credits_o stays 16.
- Credit exhaustion: one requester, ready_i=1, no returns -> exactly 16 transfers, then v_o=0 and credits_o=0. Pulse credit_return_i once -> v_o=1 on the following cycle, exactly 1 more transfer.
- Simultaneous transfer and return at credits=5 -> credits_o stays 5.
- Drain: issue 3 packets, assert drain_i -> v_o=0 from the next cycle. Return 3 credits -> drained_o=1 one cycle after credits_o reaches 16. Deassert drain_i -> issue resumes.
- Overflow: credit_return_i pulse at credits=16 -> credits_o stays 16, error_o=1 until reset_i pulses.
- Async reset mid-stream: assert reset_i between clock edges -> v_o=0, credits_o=16 immediately, without waiting for a clock edge.
